// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared FSM state type and digit-adjust constants for the BCD-to-binary converter
package bcd2bin_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble digit correction, subtract 3 from a digit that is 8 or more
module bcd_digit_adjust
    import bcd2bin_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = (d_i >= ADJ_THRESH) ? d_i - ADJ_VAL : d_i;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double dabble); BCD2BIN_DIGIT_CHECK_EN enables invalid-digit rejection
module bcd_to_bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int BIN_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);
    localparam int BCD_W = 4*N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W+1);

    state_t                   state_q;
    logic [BCD_W+BIN_W-1:0]   wr_q;
    logic [BCD_W+BIN_W-1:0]   shr;
    logic [BCD_W-1:0]         adj;
    logic [BCD_W+BIN_W-1:0]   wr_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     busy_q, done_q, err_q, bad;
    logic [BIN_W-1:0]         bin_q;

    assign shr = wr_q >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (.d_i(shr[BIN_W+4*g +: 4]), .d_o(adj[4*g +: 4]));
    end

    assign wr_d = {adj, shr[BIN_W-1:0]};

    // flag any operand digit outside 0..9 when checking is enabled
    always_comb begin
        bad = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        for (int i = 0; i < N_DIGITS; i++)
            bad = bad | (bcd_in[4*i +: 4] > BCD_MAX);
`endif
    end

    // control FSM, working register and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && bad) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        bin_q   <= '0;
                    end else if (start) begin
                        state_q <= CONV;
                        wr_q    <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CONV: begin
                    wr_q  <= wr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_W-1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bin_q   <= wr_d[BIN_W-1:0];
                        err_q   <= 1'b0;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: self-checking bench for bcd_to_bin_seq against a decimal-value reference model
module tb_bcd_to_bin_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        busy, done, err;
    logic [9:0]  bin_out;
    int          total = 0, passed = 0, last_bin = 0, pulses;

    always #5 clk = ~clk;

    bcd_to_bin_seq dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, want);
    endtask

    function automatic int bcd_val(input logic [11:0] b);
        int v = 0;
        for (int i = 2; i >= 0; i--) v = v*10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    task automatic run_conv(input logic [11:0] v);
        int want = bcd_val(v);
        start = 1'b1; bcd_in = v;
        tick;
        start = 1'b0; bcd_in = 12'($urandom);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("busy_c%0d_%03h", k, v), {busy, done}, 2'b10);
            chk($sformatf("hold_c%0d_%03h", k, v), bin_out, last_bin);
            tick;
        end
        chk($sformatf("done_%03h", v), {busy, done}, 2'b01);
        chk($sformatf("bin_%03h", v), bin_out, want);
        chk($sformatf("err_%03h", v), err, 0);
        last_bin = want;
        tick;
        chk($sformatf("after_%03h", v), {busy, done}, 2'b00);
        chk($sformatf("held_%03h", v), bin_out, last_bin);
    endtask

    initial begin
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bin", bin_out, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick;
        run_conv(12'h123);
        run_conv(12'h999);
        run_conv(12'h000);
        for (int n = 0; n < 20; n++)
            run_conv({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});

        // start pulse while busy must be ignored
        start = 1'b1; bcd_in = 12'h321;
        tick;
        start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) begin start = 1'b1; bcd_in = 12'h456; end
            if (k == 4) start = 1'b0;
            if (k == 11) begin
                chk("ign_done", done, 1);
                chk("ign_bin", bin_out, 321);
            end
            pulses += int'(done);
            tick;
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_held", bin_out, 321);
        last_bin = 321;

        // reset mid-conversion aborts without a done pulse
        start = 1'b1; bcd_in = 12'h777;
        tick;
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bin", bin_out, 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            pulses += int'(done);
            tick;
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_bin_held", bin_out, 0);
        last_bin = 0;

        // start held high gives back-to-back conversions
        start = 1'b1; bcd_in = 12'h250;
        for (int k = 1; k <= 30; k++) begin
            tick;
            chk($sformatf("b2b_done_c%0d", k), done, (k == 11 || k == 23) ? 1 : 0);
            if (done) chk($sformatf("b2b_bin_c%0d", k), bin_out, 250);
        end
        start = 1'b0;
        for (int k = 0; k < 14; k++) tick;
        chk("b2b_idle", {busy, done}, 2'b00);
        last_bin = 250;

`ifdef BCD2BIN_DIGIT_CHECK_EN
        start = 1'b1; bcd_in = 12'h1A3;
        tick;
        start = 1'b0;
        chk("inv_done", {busy, done}, 2'b01);
        chk("inv_err", err, 1);
        chk("inv_bin", bin_out, 0);
        tick;
        chk("inv_after", done, 0);
        chk("inv_err_held", err, 1);
        last_bin = 0;
        run_conv(12'h042);
`else
        run_conv(12'h042);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
